phase_sequencer: RTL

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer_if.sv | 41 ++++
 rtl/phase_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer_if.sv
// Bus between the phase sequencer and its datapath/memory environment.
// mem_e/mem_ready: mem_e is held as the request and the access completes on the first cycle where mem_e and mem_ready are both 1.
interface phase_sequencer_if #(
    parameter int CW = 16
);
    logic          run;
    logic          mem_ready;
    logic [15:0]   instruction;
    logic          S;
    logic          Z;
    logic          C;
    logic          V;
    logic [2:0]    phase;
    logic          busy;
    logic          halted;
    logic          ir_e;
    logic          ar_e;
    logic          br_e;
    logic          aluc_e;
    logic          flag_e;
    logic          mem_e;
    logic          mem_w;
    logic          genr_w;
    logic          pc_e;
    logic          jump;
    logic          illegal;
    logic [CW-1:0] retired;
    logic [1:0]    fsm_state;

    modport master (
        output run, mem_ready, instruction, S, Z, C, V,
        input  phase, busy, halted, ir_e, ar_e, br_e, aluc_e, flag_e,
               mem_e, mem_w, genr_w, pc_e, jump, illegal, retired, fsm_state
    );

    modport slave (
        input  run, mem_ready, instruction, S, Z, C, V,
        output phase, busy, halted, ir_e, ar_e, br_e, aluc_e, flag_e,
               mem_e, mem_w, genr_w, pc_e, jump, illegal, retired, fsm_state
    );
endinterface

// File: rtl/phase_sequencer.sv
// Multi-phase instruction sequencer: steps NPH phases per instruction, decodes the
// instruction class at phase 1 and drives the datapath strobes from registered state.
module phase_sequencer #(
    parameter int NPH = 5,
    parameter int CW  = 16
) (
    input  logic               clk,
    input  logic               rst,
    phase_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP, CL_ALUWB, CL_CMP, CL_IN, CL_OUT, CL_HLT, CL_LD, CL_ST,
        CL_LI, CL_B, CL_BE, CL_BLT, CL_BLE, CL_BNE, CL_ILL
    } class_t;

    localparam logic [2:0] LAST = 3'(NPH - 1);

    state_t        state;
    logic [2:0]    phase_q;
    class_t        cls;
    logic          taken;
    logic [CW-1:0] retired_q;
    logic          stall;
    logic          unused_inputs;

    function automatic class_t decode(input logic [15:0] ins);
        class_t c;
        c = CL_ILL;
        case (ins[15:14])
            2'b11: begin
                case (ins[7:4])
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6,
                    4'h8, 4'h9, 4'hA, 4'hB: c = CL_ALUWB;
                    4'h5:                   c = CL_CMP;
                    4'hC:                   c = CL_IN;
                    4'hD:                   c = CL_OUT;
                    4'hF:                   c = CL_HLT;
                    default:                c = CL_ILL;
                endcase
            end
            2'b00: c = CL_LD;
            2'b01: c = CL_ST;
            default: begin
                if (ins[13:11] == 3'b000)
                    c = CL_LI;
                else if (ins[13:11] == 3'b100)
                    c = CL_B;
                else if (ins[13:11] == 3'b111) begin
                    case (ins[10:8])
                        3'b000:  c = CL_BE;
                        3'b001:  c = CL_BLT;
                        3'b010:  c = CL_BLE;
                        3'b011:  c = CL_BNE;
                        default: c = CL_ILL;
                    endcase
                end
            end
        endcase
        return c;
    endfunction

    function automatic logic branch_taken(input class_t c, input logic s, input logic z, input logic v);
        logic t;
        case (c)
            CL_B:    t = 1'b1;
            CL_BE:   t = z;
            CL_BLT:  t = s ^ v;
            CL_BLE:  t = z | (s ^ v);
            CL_BNE:  t = ~z;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // The C flag and the low instruction nibble play no part in sequencing.
    assign unused_inputs = ^{bus.C, bus.instruction[3:0]};

    assign stall = bus.mem_e & ~bus.mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase_q   <= 3'd0;
            cls       <= CL_NOP;
            taken     <= 1'b0;
            retired_q <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (bus.run) begin
                        state   <= RUN;
                        phase_q <= 3'd0;
                    end
                end
                RUN: begin
                    if (phase_q == 3'd1) begin
                        cls   <= decode(bus.instruction);
                        taken <= branch_taken(decode(bus.instruction), bus.S, bus.Z, bus.V);
                    end
                    if (!stall) begin
                        if (phase_q == LAST) begin
                            phase_q   <= 3'd0;
                            retired_q <= retired_q + CW'(1);
                            if (cls == CL_HLT)
                                state <= HALT;
                        end else begin
                            phase_q <= phase_q + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ir_e    = 1'b0;
        bus.ar_e    = 1'b0;
        bus.br_e    = 1'b0;
        bus.aluc_e  = 1'b0;
        bus.flag_e  = 1'b0;
        bus.mem_e   = 1'b0;
        bus.mem_w   = 1'b0;
        bus.genr_w  = 1'b0;
        bus.pc_e    = 1'b0;
        bus.jump    = 1'b0;
        bus.illegal = 1'b0;
        if (state == RUN) begin
            if (phase_q == 3'd0)
                bus.ir_e = 1'b1;
            if (phase_q == 3'd1) begin
                bus.ar_e = 1'b1;
                bus.br_e = 1'b1;
            end
            if (phase_q == 3'd2) begin
                bus.aluc_e = cls inside {CL_ALUWB, CL_CMP, CL_LD, CL_ST,
                                         CL_B, CL_BE, CL_BLT, CL_BLE, CL_BNE};
                bus.flag_e = cls inside {CL_ALUWB, CL_CMP};
            end
            if (phase_q == 3'd3) begin
                bus.mem_e = cls inside {CL_LD, CL_ST, CL_IN};
                bus.mem_w = (cls == CL_ST);
            end
            // A halting instruction leaves the PC pointing at itself.
            if (phase_q == LAST) begin
                bus.pc_e    = (cls != CL_HLT);
                bus.genr_w  = cls inside {CL_ALUWB, CL_IN, CL_LD, CL_LI};
                bus.jump    = taken;
                bus.illegal = (cls == CL_ILL);
            end
        end
    end

    assign bus.phase     = phase_q;
    assign bus.busy      = (state == RUN);
    assign bus.halted    = (state == HALT);
    assign bus.retired   = retired_q;
    assign bus.fsm_state = state;
endmodule
